// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and sizes for the RC4 key-schedule blocks.
// Imported by rc4_key_byte_sel and rc4_ksa_shuffle.
package rc4_pkg;

   localparam int S_MEM_DEPTH   = 256;
   localparam int S_ADDR_W      = 8;
   localparam int DEF_KEY_BYTES = 3;

   typedef enum logic [3:0] {
      KSA_IDLE,
      KSA_READ_I,
      KSA_WAIT_I,
      KSA_GET_I,
      KSA_READ_J,
      KSA_WAIT_J,
      KSA_GET_J,
      KSA_WRITE_I,
      KSA_WRITE_J,
      KSA_ADVANCE,
      KSA_DONE
   } ksa_state_t;

   // Width of a key-byte index; never zero so a 1-byte key still has a port.
   function automatic int key_idx_w(input int kb);
      return (kb > 1) ? $clog2(kb) : 1;
   endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// rc4_key_byte_sel: picks key byte k, byte 0 being the MSB of secret_key.
// Shared by the KSA shuffle and the PRGA/decrypt stage.
module rc4_key_byte_sel
   import rc4_pkg::*;
#(
   parameter int KEY_BYTES = DEF_KEY_BYTES
) (
   input  logic [8*KEY_BYTES-1:0]          secret_key,
   input  logic [key_idx_w(KEY_BYTES)-1:0] k,
   output logic [7:0]                      key_byte
);

   // Plain mux over the key bytes; out-of-range k selects zero.
   always_comb begin
      key_byte = '0;
      for (int n = 0; n < KEY_BYTES; n++) begin
         if (int'(k) == n) begin
            key_byte = secret_key[8*(KEY_BYTES-1-n) +: 8];
         end
      end
   end

endmodule

// File: rtl/rc4_ksa_shuffle.sv
// rc4_ksa_shuffle: RC4 key-scheduling shuffle over a single-port S-memory.
// Optional macro RC4_KSA_SKIP_SELF_SWAP_EN: skip both writes when j == i.
module rc4_ksa_shuffle
   import rc4_pkg::*;
#(
   parameter int KEY_BYTES = DEF_KEY_BYTES
) (
   input  logic                   CLOCK_50,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   input  logic [7:0]             mem_rdata,
   output logic [S_ADDR_W-1:0]    mem_addr,
   output logic [7:0]             mem_wdata,
   output logic                   mem_wren,
   output logic                   busy,
   output logic                   done
);

   localparam int K_W = key_idx_w(KEY_BYTES);
   localparam logic [K_W-1:0] K_LAST = K_W'(KEY_BYTES-1);
   localparam logic [S_ADDR_W-1:0] I_LAST = S_ADDR_W'(S_MEM_DEPTH-1);

   ksa_state_t state;
   logic [S_ADDR_W-1:0] i;
   logic [S_ADDR_W-1:0] j;
   logic [K_W-1:0] k;
   logic [7:0] si;
   logic [7:0] sj;
   logic [7:0] key_byte;
   logic [7:0] j_next;
   logic wren_q;

   rc4_key_byte_sel #(
      .KEY_BYTES (KEY_BYTES)
   ) u_key_sel (
      .secret_key (secret_key),
      .k          (k),
      .key_byte   (key_byte)
   );

   assign j_next = j + mem_rdata + key_byte;

   // sj doubles as the write-data register: s[j] for WRITE_I, then s[i].
   assign mem_wdata = sj;

   // Abort must stop a write already presented this cycle.
   assign mem_wren = wren_q & ~abort;

   // Sequencer FSM, counters and registered memory-side outputs.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= KSA_IDLE;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         si       <= '0;
         sj       <= '0;
         mem_addr <= '0;
         wren_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else if (abort) begin
         state    <= KSA_IDLE;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         si       <= '0;
         sj       <= '0;
         mem_addr <= '0;
         wren_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            KSA_IDLE, KSA_DONE: begin
               if (start) begin
                  i        <= '0;
                  j        <= '0;
                  k        <= '0;
                  mem_addr <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  state    <= KSA_READ_I;
               end
            end
            KSA_READ_I: state <= KSA_WAIT_I;
            KSA_WAIT_I: state <= KSA_GET_I;
            KSA_GET_I: begin
               si       <= mem_rdata;
               j        <= j_next;
               mem_addr <= j_next;
`ifdef RC4_KSA_SKIP_SELF_SWAP_EN
               state    <= (j_next == i) ? KSA_ADVANCE : KSA_READ_J;
`else
               state    <= KSA_READ_J;
`endif
            end
            KSA_READ_J: state <= KSA_WAIT_J;
            KSA_WAIT_J: state <= KSA_GET_J;
            KSA_GET_J: begin
               sj       <= mem_rdata;
               mem_addr <= i;
               wren_q   <= 1'b1;
               state    <= KSA_WRITE_I;
            end
            KSA_WRITE_I: begin
               sj       <= si;
               mem_addr <= j;
               state    <= KSA_WRITE_J;
            end
            KSA_WRITE_J: begin
               wren_q <= 1'b0;
               state  <= KSA_ADVANCE;
            end
            KSA_ADVANCE: begin
               if (i == I_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= KSA_DONE;
               end else begin
                  i        <= i + 8'd1;
                  k        <= (k == K_LAST) ? '0 : k + K_W'(1);
                  mem_addr <= i + 8'd1;
                  state    <= KSA_READ_I;
               end
            end
            default: state <= KSA_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_ksa_shuffle.sv
// tb_rc4_ksa_shuffle: vector table, random keys and corner sequences
// checked against a software RC4 KSA model and a behavioural S-memory.
module tb_rc4_ksa_shuffle;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [23:0] secret_key = '0;
   logic [7:0]  mem_rdata;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_wren;
   logic        busy;
   logic        done;

   logic        mem_init = 1'b0;
   logic [7:0]  mem [256];
   int          wa[$];
   int          wd[$];

   int          n_pass = 0;
   int          n_total = 0;

   byte unsigned ref_s [256];
   int          ref_selfs;
   int          ref_selfs10;

   typedef struct {
      logic [23:0] key;
      int          a0;
      int          d0;
      int          a1;
      int          d1;
   } vec_t;

   vec_t vt [3];

   rc4_ksa_shuffle dut (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .secret_key (secret_key),
      .mem_rdata  (mem_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wren   (mem_wren),
      .busy       (busy),
      .done       (done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // S-memory: one-cycle read latency, write log for checking.
   always @(posedge CLOCK_50) begin
      if (mem_init) begin
         for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
      end else if (mem_wren) begin
         mem[mem_addr] <= mem_wdata;
         wa.push_back(int'(mem_addr));
         wd.push_back(int'(mem_wdata));
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic init_mem();
      @(negedge CLOCK_50);
      mem_init = 1'b1;
      @(negedge CLOCK_50);
      mem_init = 1'b0;
   endtask

   // Textbook RC4 KSA applied to a snapshot of the current memory.
   task automatic model_ksa(input logic [23:0] key);
      int jj;
      int kb;
      byte unsigned t;
      for (int n = 0; n < 256; n++) ref_s[n] = mem[n];
      jj = 0;
      ref_selfs = 0;
      ref_selfs10 = 0;
      for (int ii = 0; ii < 256; ii++) begin
         kb = int'((key >> (8 * (2 - (ii % 3)))) & 24'hFF);
         jj = (jj + int'(ref_s[ii]) + kb) % 256;
         if (jj == ii) begin
            ref_selfs++;
            if (ii < 10) ref_selfs10++;
         end
         t = ref_s[ii];
         ref_s[ii] = ref_s[jj];
         ref_s[jj] = t;
      end
   endtask

   function automatic int exp_latency();
`ifdef RC4_KSA_SKIP_SELF_SWAP_EN
      return 2304 - 5 * ref_selfs;
`else
      return 2304;
`endif
   endfunction

   function automatic int exp_writes();
`ifdef RC4_KSA_SKIP_SELF_SWAP_EN
      return 2 * (256 - ref_selfs);
`else
      return 512;
`endif
   endfunction

   function automatic int mem_mismatches();
      int m = 0;
      for (int n = 0; n < 256; n++) if (mem[n] != ref_s[n]) m++;
      return m;
   endfunction

   // Called at a negedge; poke > 0 pulses start again while busy.
   task automatic run_ksa(input logic [23:0] key, input int poke,
                          output int lat);
      secret_key = key;
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      check("busy_rise", int'(busy), 1);
      check("done_low_after_start", int'(done), 0);
      check("first_addr_i0", int'(mem_addr), 0);
      lat = 0;
      while (!done && lat < 3000) begin
         @(negedge CLOCK_50);
         lat++;
         start = (lat == poke);
      end
      start = 1'b0;
      check("busy_fall_with_done", int'(busy), 0);
   endtask

   task automatic full_run(input logic [23:0] key, input bit has_vec,
                           input vec_t v);
      int lat;
      int w0;
      int p;
      init_mem();
      model_ksa(key);
      w0 = wa.size();
      run_ksa(key, -1, lat);
      check("latency", lat, exp_latency());
      check("final_mem_mismatches", mem_mismatches(), 0);
      check("write_count", wa.size() - w0, exp_writes());
      if (has_vec) begin
         p = w0;
         while (p + 1 < wa.size() && wa[p] == wa[p+1]) p += 2;
         check("first_swap_addr0", wa[p], v.a0);
         check("first_swap_data0", wd[p], v.d0);
         check("first_swap_addr1", wa[p+1], v.a1);
         check("first_swap_data1", wd[p+1], v.d1);
      end
   endtask

   initial begin
      int lat;
      int target;
      int cnt;
      int nw;
      bit hit;

      vt[0] = '{24'h010203, 0, 1, 1, 0};
      vt[1] = '{24'h000000, 2, 3, 3, 2};
      vt[2] = '{24'h000249, 1, 3, 3, 1};

      repeat (3) @(negedge CLOCK_50);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_wren", int'(mem_wren), 0);
      check("reset_addr", int'(mem_addr), 0);
      check("reset_wdata", int'(mem_wdata), 0);
      reset_n = 1'b1;
      @(negedge CLOCK_50);

      for (int t = 0; t < 3; t++) full_run(vt[t].key, 1'b1, vt[t]);
      for (int t = 0; t < 3; t++) begin
         full_run(24'($urandom), 1'b0, vt[0]);
      end

      // start while busy is ignored; start in DONE reruns from i=0, j=0
      init_mem();
      model_ksa(24'h010203);
      run_ksa(24'h010203, 100, lat);
      check("busy_start_latency", lat, exp_latency());
      check("busy_start_mem", mem_mismatches(), 0);
      check("done_held", int'(done), 1);
      model_ksa(24'h0A0B0C);
      run_ksa(24'h0A0B0C, -1, lat);
      check("rerun_latency", lat, exp_latency());
      check("rerun_mem", mem_mismatches(), 0);

      // abort during WRITE_I of iteration 10
      init_mem();
      model_ksa(24'h010203);
`ifdef RC4_KSA_SKIP_SELF_SWAP_EN
      target = 2 * (10 - ref_selfs10);
`else
      target = 20;
`endif
      secret_key = 24'h010203;
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      cnt = 0;
      hit = 1'b0;
      for (int c = 0; c < 3000 && !hit; c++) begin
         if (mem_wren) begin
            if (cnt == target) hit = 1'b1;
            else begin
               cnt++;
               @(negedge CLOCK_50);
            end
         end else begin
            @(negedge CLOCK_50);
         end
      end
      check("abort_reached_write_i10", int'(hit), 1);
      check("abort_write_addr", int'(mem_addr), 10);
      abort = 1'b1;
      #1;
      check("abort_wren_gated", int'(mem_wren), 0);
      nw = wa.size();
      @(negedge CLOCK_50);
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_no_write", wa.size(), nw);
      check("abort_addr", int'(mem_addr), 0);

      // abort and start together: abort wins
      start = 1'b1;
      abort = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_busy", int'(busy), 0);
      @(negedge CLOCK_50);
      check("abort_start_idle", int'(busy), 0);

      // asynchronous reset mid-run
      init_mem();
      secret_key = 24'h000249;
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      repeat (50) @(negedge CLOCK_50);
      #5 reset_n = 1'b0;
      #1;
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_done", int'(done), 0);
      check("async_rst_wren", int'(mem_wren), 0);
      check("async_rst_addr", int'(mem_addr), 0);
      check("async_rst_wdata", int'(mem_wdata), 0);
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      @(negedge CLOCK_50);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
